i2c_txn_arbiter: RTL and testbench

- Shares the single I2C master FSM between two requesters (e.g. a config sequencer and a sensor poller).
- Round-robin arbitration; captures the winner's address, R/W and two data bytes, then launches the master with `start`.
- Tracks completion via the master's `free`, returns a `done`/`err` pulse to the granted requester, and recovers from a hung master using timeouts.

---
 rtl/i2c_txn_arbiter.sv | 152 +++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// i2c_txn_arbiter: round-robin share of one I2C master between two requesters
// Rev 1.0
// ============================================================================
module i2c_txn_arbiter #(
    parameter int ADDR_LEN      = 7,
    parameter int DATA_LEN      = 8,
    parameter int TO_W          = 16,
    parameter int START_TIMEOUT = 16,
    parameter int TXN_TIMEOUT   = 4000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [ADDR_LEN-1:0] addr0,
    input  logic [ADDR_LEN-1:0] addr1,
    input  logic                rw0,
    input  logic                rw1,
    input  logic [DATA_LEN-1:0] wd0_1,
    input  logic [DATA_LEN-1:0] wd0_2,
    input  logic [DATA_LEN-1:0] wd1_1,
    input  logic [DATA_LEN-1:0] wd1_2,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic                err0,
    output logic                err1,
    output logic                m_start,
    output logic [ADDR_LEN-1:0] m_add_reg,
    output logic                m_r_w,
    output logic [DATA_LEN-1:0] m_data_1,
    output logic [DATA_LEN-1:0] m_data_2,
    input  logic                m_free,
    output logic                busy,
    output logic                owner
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        BUSY    = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] START_LAST = TO_W'(START_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TXN_LAST   = TO_W'(TXN_TIMEOUT - 1);

    state_t          state;
    logic [TO_W-1:0] counter;
    logic [TO_W-1:0] counter_inc;
    logic            last_grant;
    logic            winner;

    // On a tie the requester that did not win last time goes first.
    assign winner      = (req0 && req1) ? ~last_grant : req1;
    assign counter_inc = (counter == '1) ? counter : counter + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            counter    <= '0;
            last_grant <= 1'b1;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            err0       <= 1'b0;
            err1       <= 1'b0;
            m_start    <= 1'b0;
            m_add_reg  <= '0;
            m_r_w      <= 1'b0;
            m_data_1   <= '0;
            m_data_2   <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= winner;
                        m_add_reg <= winner ? addr1 : addr0;
                        m_r_w     <= winner ? rw1   : rw0;
                        m_data_1  <= winner ? wd1_1 : wd0_1;
                        m_data_2  <= winner ? wd1_2 : wd0_2;
                        gnt0      <= ~winner;
                        gnt1      <= winner;
                        m_start   <= 1'b1;
                        counter   <= '0;
                        busy      <= 1'b1;
                        state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (!m_free) begin
                        m_start <= 1'b0;
                        counter <= '0;
                        state   <= BUSY;
                    end else if (counter == START_LAST) begin
                        // Master never acknowledged start: abort with error.
                        m_start    <= 1'b0;
                        done0      <= ~owner;
                        done1      <= owner;
                        err0       <= ~owner;
                        err1       <= owner;
                        last_grant <= owner;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        counter <= counter_inc;
                    end
                end
                BUSY: begin
                    if (m_free) begin
                        done0      <= ~owner;
                        done1      <= owner;
                        last_grant <= owner;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (counter == TXN_LAST) begin
                        // Hung master: report now, then wait for it to go idle.
                        done0      <= ~owner;
                        done1      <= owner;
                        err0       <= ~owner;
                        err1       <= owner;
                        last_grant <= owner;
                        state      <= RECOVER;
                    end else begin
                        counter <= counter_inc;
                    end
                end
                RECOVER: begin
                    if (m_free) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// tb_i2c_txn_arbiter: directed self-checking bench with a simple master model
// Rev 1.0
// ============================================================================
module tb_i2c_txn_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [6:0] addr0 = '0, addr1 = '0;
    logic       rw0 = 1'b0, rw1 = 1'b0;
    logic [7:0] wd0_1 = '0, wd0_2 = '0, wd1_1 = '0, wd1_2 = '0;
    logic       gnt0, gnt1, done0, done1, err0, err1;
    logic       m_start, m_r_w, busy, owner;
    logic [6:0] m_add_reg;
    logic [7:0] m_data_1, m_data_2;
    logic       m_free = 1'b1;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int mcnt = 0;
    int cnt_gnt1 = 0, cnt_done0 = 0, cnt_done1 = 0;
    int both_done = 0, err_no_done = 0;

    i2c_txn_arbiter #(
        .ADDR_LEN(7), .DATA_LEN(8), .TO_W(16),
        .START_TIMEOUT(16), .TXN_TIMEOUT(100)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .rw0(rw0), .rw1(rw1),
        .wd0_1(wd0_1), .wd0_2(wd0_2), .wd1_1(wd1_1), .wd1_2(wd1_2),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .m_start(m_start), .m_add_reg(m_add_reg), .m_r_w(m_r_w),
        .m_data_1(m_data_1), .m_data_2(m_data_2),
        .m_free(m_free), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // Master model. 0: drop free one cycle after start, raise it 40 cycles later;
    // 1/3: free stuck high; 2: free stuck low.
    always @(posedge clk) begin
        case (mode)
            0: begin
                if (m_free && m_start) begin
                    m_free <= 1'b0;
                    mcnt   <= 0;
                end else if (!m_free) begin
                    if (mcnt == 39) m_free <= 1'b1;
                    else            mcnt   <= mcnt + 1;
                end
            end
            2:       m_free <= 1'b0;
            default: m_free <= 1'b1;
        endcase
    end

    always @(negedge clk) begin
        cnt_gnt1  <= cnt_gnt1 + int'(gnt1);
        cnt_done0 <= cnt_done0 + int'(done0);
        cnt_done1 <= cnt_done1 + int'(done1);
        if (done0 && done1) both_done <= both_done + 1;
        if ((err0 && !done0) || (err1 && !done1)) err_no_done <= err_no_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit who, input int budget, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = who ? done1 : done0;
        end
        if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_gnt(input bit who, input int budget, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = who ? gnt1 : gnt0;
        end
        if (!seen) check("wait_gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n, hi, g1, d0;
        bit pf, ppf;

        // Reset state
        do_reset();
        check("rst_busy", busy, 0);
        check("rst_owner", owner, 0);
        check("rst_pulses", {gnt0, gnt1, done0, done1, err0, err1, m_start, m_r_w}, 0);
        check("rst_fields", {m_add_reg, m_data_1, m_data_2}, 0);

        // Single write from requester 0
        req0 = 1'b1; addr0 = 7'h50; rw0 = 1'b0; wd0_1 = 8'hA5; wd0_2 = 8'h3C;
        tick();
        check("t1_gnt0", gnt0, 1);
        check("t1_start", m_start, 1);
        check("t1_fields", {m_add_reg, m_r_w, m_data_1, m_data_2}, {7'h50, 1'b0, 8'hA5, 8'h3C});
        check("t1_busy_owner", {busy, owner}, 2'b10);
        req0 = 1'b0;
        tick();
        check("t1_gnt0_pulse", gnt0, 0);
        n = 0; pf = m_free; ppf = m_free;
        while (!done0 && n < 100) begin
            ppf = pf; pf = m_free;
            tick();
            n++;
        end
        check("t1_latency", n, 41);
        check("t1_done_err", {done0, err0}, 2'b10);
        check("t1_free_edge", {ppf, pf}, 2'b01);
        check("t1_idle", busy, 0);
        check("t1_no_side1", cnt_gnt1 + cnt_done1, 0);

        // Simultaneous requests from reset: 0, then 1, then 0 again
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 7'h11; addr1 = 7'h22;
        tick();
        check("t2_first", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0;
        wait_done(0, 100, n);
        tick();
        check("t2_second", {gnt0, gnt1}, 2'b01);
        check("t2_addr1", m_add_reg, 7'h22);
        req1 = 1'b0;
        wait_done(1, 100, n);
        check("t2_done1", {done1, err1}, 2'b10);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        check("t2_third", {gnt0, gnt1}, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        wait_done(0, 100, n);

        // Start timeout: free stuck high
        mode = 1;
        req0 = 1'b1; addr0 = 7'h2A;
        tick();
        req0 = 1'b0;
        hi = m_start ? 1 : 0;
        while (m_start && hi < 100) begin
            tick();
            if (m_start) hi++;
        end
        check("t3_start_len", hi, 16);
        check("t3_done_err", {done0, err0}, 2'b11);
        check("t3_busy", busy, 0);

        // Transaction timeout: free stuck low, req1 waits through RECOVER
        mode = 2;
        tick();
        req0 = 1'b1; addr0 = 7'h44;
        tick();
        check("t4_gnt0", gnt0, 1);
        req0 = 1'b0; req1 = 1'b1; addr1 = 7'h33;
        g1 = cnt_gnt1;
        wait_done(0, 300, n);
        check("t4_to_cycle", n, 101);
        check("t4_done_err", {done0, err0, done1}, 3'b110);
        repeat (5) tick();
        check("t4_recover_busy", busy, 1);
        check("t4_no_gnt1", cnt_gnt1 - g1, 0);
        check("t4_addr_held", m_add_reg, 7'h44);
        mode = 3;
        tick();
        mode = 0;
        wait_gnt(1, 10, n);
        check("t4_gnt1_lat", n, 2);
        check("t4_addr1", m_add_reg, 7'h33);
        req1 = 1'b0;
        wait_done(1, 100, n);
        check("t4_done1_ok", {done1, err1}, 2'b10);

        // Request from 1 arrives mid-transaction of 0
        req0 = 1'b1; addr0 = 7'h12; addr1 = 7'h34;
        tick();
        check("t6_gnt0", gnt0, 1);
        req0 = 1'b0;
        repeat (5) tick();
        req1 = 1'b1;
        g1 = cnt_gnt1;
        wait_done(0, 100, n);
        check("t6_no_early_gnt1", cnt_gnt1 - g1, 0);
        check("t6_addr_held", m_add_reg, 7'h12);
        tick();
        check("t6_gnt1", gnt1, 1);
        check("t6_addr1", m_add_reg, 7'h34);
        req1 = 1'b0;
        wait_done(1, 100, n);

        // Reset in the middle of BUSY
        req0 = 1'b1; addr0 = 7'h55;
        tick();
        req0 = 1'b0;
        repeat (3) tick();
        check("t5_in_busy", {busy, m_start}, 2'b10);
        d0 = cnt_done0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_outs", {gnt0, gnt1, done0, done1, err0, err1, m_start, busy, owner}, 0);
        check("t5_fields", {m_add_reg, m_data_1, m_data_2, m_r_w}, 0);
        tick();
        check("t5_no_done", cnt_done0 - d0, 0);
        req0 = 1'b1; addr0 = 7'h66;
        tick();
        check("t5_regrant", {gnt0, m_add_reg}, {1'b1, 7'h66});
        req0 = 1'b0;
        wait_done(0, 200, n);
        check("t5_done_ok", {done0, err0}, 2'b10);

        tick();
        check("excl_done", both_done, 0);
        check("err_without_done", err_no_done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
